// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch-prediction counter table:
// controller states, counter write operations and saturating arithmetic.
package bp_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  typedef enum logic [1:0] {
    WR_NONE = 2'd0,
    WR_SET  = 2'd1,
    WR_INC  = 2'd2,
    WR_DEC  = 2'd3
  } wr_op_e;

  // Helpers work on the widest supported counter/index; callers zero-extend and truncate.
  localparam int CTR_MAX_W = 8;
  localparam int IDX_MAX_W = 16;

  function automatic logic [CTR_MAX_W-1:0] ctr_sat_inc(input logic [CTR_MAX_W-1:0] ctr,
                                                       input int unsigned width);
    logic [CTR_MAX_W-1:0] max_v;
    max_v = CTR_MAX_W'((1 << width) - 1);
    return (ctr >= max_v) ? max_v : ctr + CTR_MAX_W'(1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_sat_dec(input logic [CTR_MAX_W-1:0] ctr,
                                                       input int unsigned width);
    logic [CTR_MAX_W-1:0] min_v;
    min_v = CTR_MAX_W'(0 * width);
    return (ctr == min_v) ? min_v : ctr - CTR_MAX_W'(1);
  endfunction

  function automatic logic [IDX_MAX_W-1:0] idx_hash(input logic [IDX_MAX_W-1:0] pc_bits,
                                                    input logic [IDX_MAX_W-1:0] ghr);
    return pc_bits ^ ghr;
  endfunction

endpackage

// File: rtl/bp_ctr_ram.sv
// Counter storage: one synchronous read port (old data on collision) and one
// write port that either loads a value or applies a saturating step in place.
module bp_ctr_ram
  import bp_pkg::*;
#(
  parameter int CTR_W = 2,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [CTR_W-1:0] o_rd_data,
  input  wr_op_e           i_wr_op,
  input  logic [IDX_W-1:0] i_wr_addr,
  input  logic [CTR_W-1:0] i_wr_data
);

  localparam int DEPTH = 1 << IDX_W;

  logic [CTR_W-1:0] r_mem [DEPTH];
  logic [CTR_W-1:0] r_rd_data;
  logic [CTR_W-1:0] w_cur;
  logic [CTR_W-1:0] w_inc;
  logic [CTR_W-1:0] w_dec;

  assign w_cur = r_mem[i_wr_addr];
  assign w_inc = CTR_W'(ctr_sat_inc(CTR_MAX_W'(w_cur), CTR_W));
  assign w_dec = CTR_W'(ctr_sat_dec(CTR_MAX_W'(w_cur), CTR_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    case (i_wr_op)
      WR_SET:  r_mem[i_wr_addr] <= i_wr_data;
      WR_INC:  r_mem[i_wr_addr] <= w_inc;
      WR_DEC:  r_mem[i_wr_addr] <= w_dec;
      default: ;
    endcase
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/bp_counter_table.sv
// Table of saturating branch-prediction counters, bimodal or gshare indexed,
// with a post-reset sweep that loads every entry before lookups are accepted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | sweeping INIT_VAL into every entry; lookups/updates ignored
// ST_RUN  | ready; lookups answered next cycle, updates applied
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int               CTR_W    = 2,
  parameter int               IDX_W    = 6,
  parameter int               HIST_W   = 0,
  parameter int               PC_W     = 32,
  parameter logic [CTR_W-1:0] INIT_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  output logic             ready,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_out_valid,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  bp_state_e        r_state;
  logic [IDX_W-1:0] r_init_ptr;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_pred_idx;

  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_ghr_ext;
  logic [IDX_W-1:0] w_lookup_idx;
  logic             w_lookup;
  logic             w_upd;
  wr_op_e           w_wr_op;
  logic [IDX_W-1:0] w_wr_addr;
  logic [CTR_W-1:0] w_rd_data;
  logic             w_unused_pc;

  assign w_pc_idx    = pred_pc[IDX_W+1:2];
  assign w_unused_pc = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0]};

  assign ready    = (r_state == ST_RUN);
  assign w_lookup = pred_valid & ready;
  assign w_upd    = upd_valid & ready;

  generate
    if (HIST_W > 0) begin : g_ghr
      logic [HIST_W-1:0] r_ghr;
      // Shift in the outcome; truncation drops the oldest bit (also covers HIST_W == 1).
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ghr <= '0;
        end else if (w_upd) begin
          r_ghr <= HIST_W'({r_ghr, upd_taken});
        end
      end
      assign w_ghr_ext = IDX_W'(r_ghr);
    end else begin : g_no_ghr
      assign w_ghr_ext = '0;
    end
  endgenerate

  assign w_lookup_idx = IDX_W'(idx_hash(IDX_MAX_W'(w_pc_idx), IDX_MAX_W'(w_ghr_ext)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_ptr <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_ptr <= r_init_ptr + IDX_W'(1);
      if (r_init_ptr == '1) begin
        r_state <= ST_RUN;
      end
    end
  end

  // The init sweep owns the write port; resolved branches only write once running.
  always_comb begin
    w_wr_op   = WR_NONE;
    w_wr_addr = upd_idx;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        w_wr_op   = WR_SET;
        w_wr_addr = r_init_ptr;
      end else if (upd_valid) begin
        w_wr_op = upd_taken ? WR_INC : WR_DEC;
      end
    end
  end

  bp_ctr_ram #(
    .CTR_W (CTR_W),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_rd_en   (w_lookup),
    .i_rd_addr (w_lookup_idx),
    .o_rd_data (w_rd_data),
    .i_wr_op   (w_wr_op),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (INIT_VAL)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_pred_idx  <= '0;
    end else begin
      r_out_valid <= w_lookup;
      if (w_lookup) begin
        r_pred_idx <= w_lookup_idx;
      end
    end
  end

  assign pred_out_valid = r_out_valid;
  assign pred_taken     = w_rd_data[CTR_W-1];
  assign pred_idx       = r_pred_idx;

endmodule

// File: tb/tb_bp_counter_table.sv
// Bench for bp_counter_table: three instances (bimodal 2-bit, gshare HIST_W=4,
// 3-bit counters initialised to 3) on a shared stimulus bus with a reference model.
module tb_bp_counter_table;

  logic        clk;
  logic        rst;
  logic        pv;
  logic [31:0] pc;
  logic        uv;
  logic [5:0]  ui;
  logic        ut;

  logic       rdy  [3];
  logic       ov   [3];
  logic       pt   [3];
  logic [5:0] pidx [3];

  int n_err;
  int n_checks;

  bp_counter_table #(.CTR_W(2), .IDX_W(6), .HIST_W(0), .PC_W(32), .INIT_VAL(2'b11)) u_bim (
    .clk(clk), .rst(rst), .ready(rdy[0]), .pred_valid(pv), .pred_pc(pc),
    .pred_out_valid(ov[0]), .pred_taken(pt[0]), .pred_idx(pidx[0]),
    .upd_valid(uv), .upd_idx(ui), .upd_taken(ut));

  bp_counter_table #(.CTR_W(2), .IDX_W(6), .HIST_W(4), .PC_W(32), .INIT_VAL(2'b11)) u_gsh (
    .clk(clk), .rst(rst), .ready(rdy[1]), .pred_valid(pv), .pred_pc(pc),
    .pred_out_valid(ov[1]), .pred_taken(pt[1]), .pred_idx(pidx[1]),
    .upd_valid(uv), .upd_idx(ui), .upd_taken(ut));

  bp_counter_table #(.CTR_W(3), .IDX_W(6), .HIST_W(0), .PC_W(32), .INIT_VAL(3'd3)) u_c3 (
    .clk(clk), .rst(rst), .ready(rdy[2]), .pred_valid(pv), .pred_pc(pc),
    .pred_out_valid(ov[2]), .pred_taken(pt[2]), .pred_idx(pidx[2]),
    .upd_valid(uv), .upd_idx(ui), .upd_taken(ut));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model, one slot per instance.
  int m_max   [3] = '{3, 3, 7};
  int m_initv [3] = '{3, 3, 3};
  int m_shift [3] = '{1, 1, 2};
  int m_hmask [3] = '{0, 15, 0};
  int m_tab   [3][64];
  int m_ghr   [3];
  bit m_ready;
  int m_icnt;

  typedef struct packed {
    logic       v;
    logic       t;
    logic [5:0] idx;
  } resp_t;

  resp_t exp_q[$];

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        uv;
    logic [5:0]  ui;
    logic        ut;
    logic        exp_t;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic a_pv, input logic [31:0] a_pc, input logic a_uv,
                      input logic [5:0] a_ui, input logic a_ut);
    resp_t r;
    int    idx;
    pv = a_pv;
    pc = a_pc;
    uv = a_uv;
    ui = a_ui;
    ut = a_ut;
    for (int k = 0; k < 3; k++) begin
      idx   = ((int'(a_pc) >>> 2) ^ m_ghr[k]) & 63;
      r.v   = a_pv & m_ready;
      r.idx = 6'(idx);
      r.t   = 1'((m_tab[k][idx] >> m_shift[k]) & 1);
      exp_q.push_back(r);
    end
    if (m_ready && a_uv) begin
      for (int k = 0; k < 3; k++) begin
        if (a_ut) m_tab[k][a_ui] = (m_tab[k][a_ui] == m_max[k]) ? m_max[k] : m_tab[k][a_ui] + 1;
        else      m_tab[k][a_ui] = (m_tab[k][a_ui] == 0) ? 0 : m_tab[k][a_ui] - 1;
        m_ghr[k] = ((m_ghr[k] << 1) | int'(a_ut)) & m_hmask[k];
      end
    end
    if (!m_ready) begin
      m_icnt++;
      if (m_icnt == 64) begin
        m_ready = 1'b1;
        for (int k = 0; k < 3; k++)
          for (int e = 0; e < 64; e++) m_tab[k][e] = m_initv[k];
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      r = exp_q.pop_front();
      chk($sformatf("ready[%0d]", k), 32'(rdy[k]), 32'(m_ready));
      chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(r.v));
      if (r.v) begin
        chk($sformatf("taken[%0d]", k), 32'(pt[k]), 32'(r.t));
        chk($sformatf("idx[%0d]", k), 32'(pidx[k]), 32'(r.idx));
      end
    end
  endtask

  // Reset with a lookup and update pending: both must be dropped.
  task automatic do_reset();
    pv  = 1'b1;
    pc  = 32'h0000_0104;
    uv  = 1'b1;
    ui  = 6'd1;
    ut  = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ready[%0d]", k), 32'(rdy[k]), 32'd0);
      chk($sformatf("rst_out_valid[%0d]", k), 32'(ov[k]), 32'd0);
      chk($sformatf("rst_taken[%0d]", k), 32'(pt[k]), 32'd0);
      chk($sformatf("rst_idx[%0d]", k), 32'(pidx[k]), 32'd0);
    end
    rst = 1'b0;
    pv  = 1'b0;
    uv  = 1'b0;
    m_ready = 1'b0;
    m_icnt  = 0;
    for (int k = 0; k < 3; k++) m_ghr[k] = 0;
    exp_q.delete();
  endtask

  // Random lookups and updates during the sweep must all be ignored.
  task automatic init_sweep();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, $urandom, 1'b1, 6'($urandom), 1'($urandom));
      chk("ready_rise", 32'(rdy[0]), (i == 63) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    n_err    = 0;
    n_checks = 0;
    pv = 1'b0; pc = '0; uv = 1'b0; ui = '0; ut = 1'b0;
    m_ready = 1'b0;
    m_icnt  = 0;
    for (int k = 0; k < 3; k++) m_ghr[k] = 0;

    vecs[0] = '{1'b1, 32'h100, 1'b1, 6'd0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 32'h100, 1'b1, 6'd0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 32'h100, 1'b1, 6'd0, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h100, 1'b1, 6'd0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h100, 1'b1, 6'd0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h100, 1'b0, 6'd0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h100, 1'b1, 6'd0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h100, 1'b1, 6'd0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 32'h100, 1'b1, 6'd0, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 32'h100, 1'b0, 6'd0, 1'b0, 1'b1};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    init_sweep();

    // 3-bit counters at 3: not taken until one taken update lifts them to 4.
    step(1'b1, 32'h80, 1'b0, 6'd0, 1'b0);
    chk("c3_first_lookup", 32'(pt[2]), 32'd0);
    step(1'b0, 32'h0, 1'b1, 6'h20, 1'b1);
    step(1'b1, 32'h80, 1'b0, 6'd0, 1'b0);
    chk("c3_after_taken", 32'(pt[2]), 32'd1);

    for (int i = 0; i < 6; i++) begin
      step(1'b1, $urandom, 1'b0, 6'd0, 1'b0);
      chk("bim_default_taken", 32'(pt[0]), 32'd1);
    end

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].pv, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].ut);
      chk($sformatf("bim_vec%0d", i), 32'(pt[0]), 32'(vecs[i].exp_t));
    end

    // Lookup and update on the same entry: lookup sees the old counter.
    step(1'b0, 32'h0, 1'b1, 6'd5, 1'b0);
    step(1'b1, 32'h14, 1'b1, 6'd5, 1'b0);
    chk("collision_old", 32'(pt[0]), 32'd1);
    step(1'b1, 32'h14, 1'b0, 6'd0, 1'b0);
    chk("collision_new", 32'(pt[0]), 32'd0);

    do_reset();
    init_sweep();
    step(1'b0, 32'h0, 1'b1, 6'd10, 1'b1);
    step(1'b0, 32'h0, 1'b1, 6'd10, 1'b1);
    step(1'b0, 32'h0, 1'b1, 6'd10, 1'b0);
    step(1'b0, 32'h0, 1'b1, 6'd10, 1'b1);
    step(1'b1, 32'h0, 1'b0, 6'd0, 1'b0);
    chk("gshare_idx", 32'(pidx[1]), 32'h0D);

    for (int i = 0; i < 10; i++) step(1'($urandom), $urandom, 1'b1, 6'($urandom), 1'($urandom));
    do_reset();
    init_sweep();
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 32'(i << 2), 1'b0, 6'd0, 1'b0);
      chk("post_rst_entry", 32'(pt[0]), 32'd1);
    end
    step(1'b1, 32'h0, 1'b0, 6'd0, 1'b0);
    chk("post_rst_ghr", 32'(pidx[1]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
